// File: rtl/skylark_mem_pkg.sv
// rtl/skylark_mem_pkg.sv - shared types and constants for the unified memory port arbiter
`timescale 1ns/1ps
package skylark_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    // Read data returned to the owner of a transaction that timed out
    localparam logic [31:0] ARB_ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_timeout_timer.sv
// rtl/mem_timeout_timer.sv - per-transaction cycle counter that flags expiry after LIMIT busy cycles
`timescale 1ns/1ps
module mem_timeout_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    // Count busy cycles; held at zero while idle so each transaction starts fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Expiry fires during the LIMIT-th busy cycle
    assign o_expire = i_en & (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
`timescale 1ns/1ps
module mem_port_arbiter
    import skylark_mem_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_fetch,
    output logic        stall_data,
    output logic        bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    arb_owner_t  r_owner;
    logic [31:0] r_txn_addr;
    logic        r_txn_we;
    logic [31:0] r_txn_wdata;
    logic [SW-1:0] r_starve;
    logic        r_bus_err;

    logic        w_idle;
    logic        w_busy;
    logic        w_fetch_first;
    logic        w_grant_fetch;
    logic        w_grant_data;
    logic        w_rsp;
    logic        w_redirect;
    logic        w_expire;
    logic        w_tmo;
    logic        w_if_valid;
    logic        w_d_valid;
    logic [31:0] w_rdata;

    assign w_idle = (r_state == IDLE);
    assign w_busy = (r_state == REQ) || (r_state == RESP);

    // Data normally wins; a fetch starved for STARVE_LIMIT data grants goes first
    assign w_fetch_first = if_req & (r_starve == STARVE_MAX);
    assign w_grant_fetch = w_idle & if_req & (w_fetch_first | ~d_req);
    assign w_grant_data  = w_idle & d_req & ~w_fetch_first;

    assign w_rsp      = (r_state == RESP) & mem_rvalid;
    assign w_redirect = w_rsp & (r_owner == OWN_FETCH) & (if_addr != r_txn_addr);
    // A genuine response in the final cycle takes precedence over the abort
    assign w_tmo      = w_expire & ~w_rsp;

    mem_timeout_timer #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_idle),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and completion strobes
    always_comb begin
        w_next_state = r_state;
        w_if_valid   = 1'b0;
        w_d_valid    = 1'b0;
        w_rdata      = mem_rdata;
        case (r_state)
            IDLE: begin
                if (w_grant_fetch || w_grant_data) w_next_state = REQ;
            end
            REQ: begin
                if (w_tmo)        w_next_state = IDLE;
                else if (mem_gnt) w_next_state = RESP;
            end
            RESP: begin
                if (w_tmo || mem_rvalid) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_tmo) begin
            w_rdata    = ARB_ERR_RDATA;
            w_if_valid = (r_owner == OWN_FETCH);
            w_d_valid  = (r_owner == OWN_DATA);
        end else if (w_rsp) begin
            w_if_valid = (r_owner == OWN_FETCH) & ~w_redirect;
            w_d_valid  = (r_owner == OWN_DATA);
        end
    end

    // Capture the granted request so the memory sees stable signals until accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_FETCH;
            r_txn_addr  <= '0;
            r_txn_we    <= 1'b0;
            r_txn_wdata <= '0;
        end else if (w_grant_fetch) begin
            r_owner     <= OWN_FETCH;
            r_txn_addr  <= if_addr;
            r_txn_we    <= 1'b0;
            r_txn_wdata <= '0;
        end else if (w_grant_data) begin
            r_owner     <= OWN_DATA;
            r_txn_addr  <= d_addr;
            r_txn_we    <= d_we;
            r_txn_wdata <= d_wdata;
        end
    end

    // Count data grants taken while a fetch waits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!if_req || w_grant_fetch) begin
            r_starve <= '0;
        end else if (w_grant_data && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (w_tmo) begin
            r_bus_err <= 1'b1;
        end
    end

    assign mem_req     = (r_state == REQ);
    assign mem_we      = mem_req & r_txn_we;
    assign mem_addr    = r_txn_addr;
    assign mem_wdata   = r_txn_wdata;

    assign if_valid    = w_if_valid;
    assign d_valid     = w_d_valid;
    assign if_rdata    = w_if_valid ? w_rdata : '0;
    assign d_rdata     = w_d_valid  ? w_rdata : '0;

    assign stall_fetch = if_req & ~w_if_valid;
    assign stall_data  = d_req & ~w_d_valid;
    assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_fetch;
    logic        stall_data;
    logic        bus_err;

    mem_port_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_valid    (if_valid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_valid     (d_valid),
        .d_rdata     (d_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall_fetch (stall_fetch),
        .stall_data  (stall_data),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] fq[$];
    logic [31:0] dq[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit          gnt_en    = 1'b1;
    bit          rsp_en    = 1'b1;
    bit          stray_req = 1'b0;
    bit          pend;
    logic [31:0] pend_addr;
    logic        pend_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic mreq_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd);
        mreq_t r;
        r.addr  = a;
        r.we    = we;
        r.wdata = wd;
        return r;
    endfunction

    // Memory model: grants a held request, answers one cycle later, checks issue order
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; pend = 1'b0;
        pend_addr = '0; pend_we = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            mem_gnt    = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (stray_req) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hDEAD_BEEF;
                end else if (pend && rsp_en) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_we ? 32'h0 : mem_word(pend_addr);
                    pend = 1'b0;
                end
                if (mem_req && gnt_en) begin
                    mreq_t e;
                    mem_gnt = 1'b1;
                    pend = 1'b1; pend_addr = mem_addr; pend_we = mem_we;
                    if (mq.size() == 0) begin
                        check("mem_req_unexpected", 65'({mem_addr, mem_we}), 65'h0);
                    end else begin
                        e = mq.pop_front();
                        check("mem_req_order", {mem_addr, mem_we, mem_wdata}, {e.addr, e.we, e.wdata});
                    end
                end
            end
        end
    end

    // Monitor: compares every delivered response against the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            check("stall_fetch", 65'(stall_fetch), 65'(if_req & ~if_valid));
            check("stall_data", 65'(stall_data), 65'(d_req & ~d_valid));
            if (if_valid) begin
                if (fq.size() == 0) check("if_valid_unexpected", 65'(if_rdata), 65'h1_0000_0000);
                else begin e = fq.pop_front(); check("if_rdata", 65'(if_rdata), 65'(e)); end
            end
            if (d_valid) begin
                if (dq.size() == 0) check("d_valid_unexpected", 65'(d_rdata), 65'h1_0000_0000);
                else begin e = dq.pop_front(); check("d_rdata", 65'(d_rdata), 65'(e)); end
            end
        end
    end

    task automatic wait_valid(input bit is_data, output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            seen = is_data ? d_valid : if_valid;
        end
        if (!seen) check(is_data ? "d_valid_timeout" : "if_valid_timeout", 65'h0, 65'h1);
    endtask

    task automatic fetch_txn(input logic [31:0] a, output int lat);
        if_addr = a; if_req = 1'b1;
        wait_valid(1'b0, lat);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input bit keep, output int lat);
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_valid(1'b1, lat);
        @(posedge clk); #1;
        if (!keep) d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat_f, lat_d, lat;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem", 65'({mem_req, mem_we, mem_addr, mem_wdata}), 65'h0);
        check("rst_valid", 65'({if_valid, d_valid, if_rdata, d_rdata}), 65'h0);
        check("rst_bus_err", 65'(bus_err), 65'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // single fetch, minimum latency
        mq.push_back(mk(32'h100, 1'b0, 32'h0));
        fq.push_back(32'h0050_0093);
        fetch_txn(32'h100, lat_f);
        check("fetch_latency", 65'(lat_f), 65'd2);
        @(negedge clk);
        check("stall_fetch_after", 65'(stall_fetch), 65'h0);
        @(posedge clk); #1;

        // simultaneous requests: store first, then fetch
        mq.push_back(mk(32'h2000, 1'b1, 32'hCAFE_BABE));
        mq.push_back(mk(32'h104, 1'b0, 32'h0));
        dq.push_back(32'h0);
        fq.push_back(32'h5A5A_0104);
        fork
            data_txn(1'b1, 32'h2000, 32'hCAFE_BABE, 1'b0, lat_d);
            fetch_txn(32'h104, lat_f);
        join
        check("store_latency", 65'(lat_d), 65'd2);
        check("fetch_after_store_latency", 65'(lat_f), 65'd5);
        repeat (2) @(posedge clk); #1;

        // starvation: four loads, then the fetch, then remaining loads
        for (int i = 0; i < 4; i++) mq.push_back(mk(32'h3000 + 32'(4 * i), 1'b0, 32'h0));
        mq.push_back(mk(32'h108, 1'b0, 32'h0));
        for (int i = 4; i < 6; i++) mq.push_back(mk(32'h3000 + 32'(4 * i), 1'b0, 32'h0));
        for (int i = 0; i < 6; i++) dq.push_back(32'h5A5A_3000 + 32'(4 * i));
        fq.push_back(32'h5A5A_0108);
        fork
            begin
                for (int i = 0; i < 6; i++) data_txn(1'b0, 32'h3000 + 32'(4 * i), 32'h0, i < 5, lat);
            end
            fetch_txn(32'h108, lat_f);
        join
        repeat (2) @(posedge clk); #1;

        // fetch redirect while the response is in flight
        mq.push_back(mk(32'h100, 1'b0, 32'h0));
        mq.push_back(mk(32'h200, 1'b0, 32'h0));
        fq.push_back(32'h5A5A_0200);
        if_addr = 32'h100; if_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #2;
        if_addr = 32'h200;
        wait_valid(1'b0, lat_f);
        check("redirect_reissue_latency", 65'(lat_f), 65'd3);
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // timeout: memory never grants
        gnt_en = 1'b0;
        dq.push_back(32'h0);
        data_txn(1'b0, 32'h5000, 32'h0, 1'b0, lat_d);
        check("timeout_latency", 65'(lat_d), 65'd8);
        @(negedge clk);
        check("bus_err_set", 65'(bus_err), 65'h1);
        check("idle_after_timeout", 65'(mem_req), 65'h0);
        gnt_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bus_err_sticky", 65'(bus_err), 65'h1);

        // reset in RESP, then a stray response
        @(posedge clk); #1;
        rsp_en = 1'b0;
        mq.push_back(mk(32'h6000, 1'b0, 32'h0));
        d_we = 1'b0; d_addr = 32'h6000; d_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("rst_mid_mem", 65'({mem_req, mem_we, mem_addr}), 65'h0);
        check("rst_mid_valid", 65'({d_valid, d_rdata}), 65'h0);
        check("rst_mid_bus_err", 65'(bus_err), 65'h0);
        check("rst_mid_stall_data", 65'(stall_data), 65'h1);
        @(posedge clk); #2;
        d_req = 1'b0; reset = 1'b0; rsp_en = 1'b1;
        @(posedge clk); #2;
        stray_req = 1'b1;
        @(posedge clk); #2;
        stray_req = 1'b0;
        @(negedge clk);
        check("stray_rvalid_present", 65'(mem_rvalid), 65'h1);
        check("stray_no_valid", 65'({if_valid, d_valid}), 65'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("mq_empty", 65'(mq.size()), 65'h0);
        check("fq_empty", 65'(fq.size()), 65'h0);
        check("dq_empty", 65'(dq.size()), 65'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the Fetch-stage instruction port and the Writeback-stage load/store port. It sequences one outstanding memory transaction at a time through a req/gnt/rvalid handshake. It generates the fetch and data stall requests consumed by the hazard control unit, and bounds every transaction with a timeout.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch is pending before fetch is forced.
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ+RESP before the transaction is aborted.
- Clock and reset: one clock, `clk`; reset is `reset`, asynchronous and active-high.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous active-high reset.
- `if_req` input 1: fetch requests the word at `if_addr`.
- `if_addr` input 32: fetch address (PCF).
- `if_valid` output 1: `if_rdata` valid this cycle.
- `if_rdata` output 32: instruction word.
- `d_req` input 1: load/store request.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data address (ALUResultW).
- `d_wdata` input 32: store data (WD).
- `d_valid` output 1: load data valid, or store acknowledged.
- `d_rdata` output 32: load data.
- `mem_req` output 1: request to memory.
- `mem_we` output 1: write strobe.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_gnt` input 1: memory accepted the request.
- `mem_rvalid` input 1: response is valid; returned for both reads and writes.
- `mem_rdata` input 32: read data.
- `stall_fetch` output 1: hold Fetch.
- `stall_data` output 1: hold Writeback and everything older.
- `bus_err` output 1: sticky; set on timeout.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: `mem_req` held, waiting for `mem_gnt`.
  - RESP: waiting for `mem_rvalid`.
- Arbitration happens in IDLE only:
  - Data wins over fetch, because the data access belongs to the older instruction.
  - Fetch wins instead when `starve_cnt == STARVE_LIMIT`.
- `starve_cnt`:
  - Increments on each data grant while `if_req` is high.
  - Clears on any fetch grant or when `if_req` is low.
  - Saturates at `STARVE_LIMIT`.
- On a grant in IDLE:
  - Latch owner, address, we and wdata into `txn_*` registers.
  - Go to REQ.
  - `mem_*` outputs are driven only from the `txn_*` registers and stay stable until `mem_gnt`.
- Transitions:
  - REQ with `mem_gnt` → RESP.
  - RESP with `mem_rvalid` → IDLE.
- Completion:
  - `x_valid = mem_rvalid & (owner == x)` in RESP.
  - `x_rdata` passes `mem_rdata` through.
- Fetch redirect: if `if_addr != txn_addr` when the fetch response arrives, suppress `if_valid`, drop the data, and return to IDLE so the new address is reissued.
- `stall_fetch = if_req & ~if_valid`.
- `stall_data = d_req & ~d_valid`.
- Timeout:
  - `tmo_cnt` counts cycles spent in REQ or RESP.
  - Reaching `TIMEOUT_CYCLES` forces IDLE.
  - The owner receives a `x_valid` pulse with `x_rdata = 0`.
  - `bus_err` is set and stays set until reset.
- A `mem_rvalid` in IDLE or REQ is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - `mem_req`, `mem_we`: 0.
  - `mem_addr`, `mem_wdata`: 0.
  - `if_valid`, `d_valid`: 0.
  - `if_rdata`, `d_rdata`: 0.
  - `bus_err`: 0.
  - `starve_cnt`, `tmo_cnt`: 0.
  - `stall_x` equals `x_req`.
- Minimum latency, request to valid, is 2 cycles:
  - Cycle 0: grant, then REQ.
  - Cycle 1: `mem_req` high, `mem_gnt` high.
  - Cycle 2: `mem_rvalid` high, `x_valid` high.
- The arbiter is back in IDLE on the cycle after valid, so back-to-back throughput is one transaction per 3 cycles.
- Simultaneous `if_req` and `d_req` in IDLE: data is granted and `stall_fetch` stays high.
- Reset asserted mid-transaction: the FSM drops to IDLE immediately, with no response delivered. The memory must also be reset.
- Requesters hold req, addr and data stable until their valid. Deasserting a req mid-transaction does not cancel it; the response is still consumed.

## Structure
- `skylark_mem_pkg`:
  - `arb_state_t` enum {IDLE, REQ, RESP}.
  - `arb_owner_t` enum {OWN_FETCH, OWN_DATA}.
  - Timeout read-data constant `ARB_ERR_RDATA = 32'h0`.
- Sub-module `mem_timeout_timer`: load/clear/expire counter of width `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Single fetch at 0x100, with `mem_gnt` in the REQ cycle and `mem_rvalid` one cycle later returning 0x00500093 → `if_valid` high for 1 cycle 2 cycles after the request, `if_rdata`=0x00500093, `stall_fetch` low afterward.
- `if_req` and `d_req` (store 0xCAFEBABE to 0x2000) in the same cycle → `mem_we`=1 with address 0x2000 first, the fetch is issued after `d_valid`, and `stall_fetch` is high throughout.
- `d_req` held for 6 back-to-back loads with `if_req` high, `STARVE_LIMIT`=4 → the 5th grant goes to fetch, then data resumes.
- Fetch at 0x100 in RESP while `if_addr` changes to 0x200 → the response is dropped with no `if_valid`, then `mem_addr`=0x200 is issued and returns valid.
- `mem_gnt` never asserted, `TIMEOUT_CYCLES`=8 → after 8 cycles `d_valid` pulses with `d_rdata`=0, `bus_err` goes to 1 and stays 1, and the FSM is in IDLE.
- `reset` asserted in RESP → all outputs at reset values the same cycle, and a later stray `mem_rvalid` produces no valid.
